// File: rtl/speed_select.sv
// speed_select: three pushbuttons (up, down, stop) turned into a saturating
// 8-bit speed setting and a stop toggle. Each button is synchronized, then
// debounced against a 1 ms tick. Holding exactly one direction button
// auto-repeats the step.
module speed_select #(
   parameter int unsigned TICK_M     = 100_000,
   parameter int unsigned DB_MS      = 20,
   parameter int unsigned HOLD_MS    = 500,
   parameter int unsigned RPT_MS     = 100,
   parameter int unsigned STEP       = 8,
   parameter int unsigned INIT_SPEED = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_stop,
   output logic [7:0] speed,
   output logic       stop,
   output logic       changed
);

   localparam int unsigned PRE_W    = $clog2(TICK_M + 1);
   localparam int unsigned DB_W     = $clog2(DB_MS + 1);
   localparam int unsigned HOLD_MAX = (HOLD_MS > RPT_MS) ? HOLD_MS : RPT_MS;
   localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

   // Button indices shared by the synchronizer, debouncer and press vectors.
   localparam int B_UP   = 0;
   localparam int B_DN   = 1;
   localparam int B_STOP = 2;

   typedef enum logic [1:0] {
      DB_LOW       = 2'd0,
      DB_WAIT_HIGH = 2'd1,
      DB_HIGH      = 2'd2,
      DB_WAIT_LOW  = 2'd3
   } db_state_e;

   logic [2:0]        sync1_q, sync1_d;
   logic [2:0]        sync2_q, sync2_d;
   logic [PRE_W-1:0]  presc_q, presc_d;
   logic              tick;

   db_state_e         db_state_q [3];
   db_state_e         db_state_d [3];
   logic [DB_W-1:0]   db_cnt_q   [3];
   logic [DB_W-1:0]   db_cnt_d   [3];
   logic [2:0]        press_q, press_d;
   logic [1:0]        level;

   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              rpt_phase_q, rpt_phase_d;
   logic              rpt_up_q, rpt_up_d;
   logic              rpt_dn_q, rpt_dn_d;

   logic [7:0]        speed_q, speed_d;
   logic              stop_q, stop_d;
   logic              changed_q, changed_d;
   logic [8:0]        sum9, diff9;
   logic              up_req, dn_req, conflict;

   // Two-stage synchronizer input and the free-running prescaler.
   always_comb begin
      sync1_d = {btn_stop, btn_down, btn_up};
      sync2_d = sync1_q;
      tick    = (presc_q == PRE_W'(TICK_M - 1));
      presc_d = tick ? '0 : presc_q + PRE_W'(1);
   end

   // State register for synchronizers, prescaler and debounce FSMs.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         presc_q <= '0;
         press_q <= '0;
         for (int i = 0; i < 3; i++) begin
            db_state_q[i] <= DB_LOW;
            db_cnt_q[i]   <= '0;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         presc_q <= presc_d;
         press_q <= press_d;
         for (int i = 0; i < 3; i++) begin
            db_state_q[i] <= db_state_d[i];
            db_cnt_q[i]   <= db_cnt_d[i];
         end
      end
   end

   // Debounce next-state: a level is accepted after DB_MS stable ticks.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         db_state_d[i] = db_state_q[i];
         db_cnt_d[i]   = db_cnt_q[i];
         case (db_state_q[i])
            DB_LOW: begin
               if (sync2_q[i]) begin
                  db_state_d[i] = DB_WAIT_HIGH;
                  db_cnt_d[i]   = '0;
               end
            end
            DB_WAIT_HIGH: begin
               if (!sync2_q[i]) begin
                  db_state_d[i] = DB_LOW;
               end else if (tick) begin
                  if (db_cnt_q[i] == DB_W'(DB_MS - 1)) db_state_d[i] = DB_HIGH;
                  else db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
               end
            end
            DB_HIGH: begin
               if (!sync2_q[i]) begin
                  db_state_d[i] = DB_WAIT_LOW;
                  db_cnt_d[i]   = '0;
               end
            end
            DB_WAIT_LOW: begin
               if (sync2_q[i]) begin
                  db_state_d[i] = DB_HIGH;
               end else if (tick) begin
                  if (db_cnt_q[i] == DB_W'(DB_MS - 1)) db_state_d[i] = DB_LOW;
                  else db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
               end
            end
            default: db_state_d[i] = DB_LOW;
         endcase
      end
   end

   // Debounce outputs: press pulse on entry to HIGH, level for direction buttons.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         press_d[i] = (db_state_q[i] == DB_WAIT_HIGH) && (db_state_d[i] == DB_HIGH);
      end
      for (int i = 0; i < 2; i++) begin
         level[i] = (db_state_q[i] == DB_HIGH) || (db_state_q[i] == DB_WAIT_LOW);
      end
   end

   // Auto-repeat: HOLD_MS ticks to the first repeat, then one every RPT_MS ticks.
   always_comb begin
      hold_cnt_d  = hold_cnt_q;
      rpt_phase_d = rpt_phase_q;
      rpt_up_d    = 1'b0;
      rpt_dn_d    = 1'b0;
      if (!(level[B_UP] ^ level[B_DN]) || (press_q[B_UP] && press_q[B_DN])) begin
         hold_cnt_d  = '0;
         rpt_phase_d = 1'b0;
      end else if (tick) begin
         if (hold_cnt_q == (rpt_phase_q ? HOLD_W'(RPT_MS - 1) : HOLD_W'(HOLD_MS - 1))) begin
            hold_cnt_d  = '0;
            rpt_phase_d = 1'b1;
            rpt_up_d    = level[B_UP];
            rpt_dn_d    = level[B_DN];
         end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
         end
      end
   end

   // Saturating speed update, stop toggle and change detection.
   always_comb begin
      up_req   = press_q[B_UP] | rpt_up_q;
      dn_req   = press_q[B_DN] | rpt_dn_q;
      conflict = (level[B_UP] && level[B_DN]) || (up_req && dn_req);
      sum9     = {1'b0, speed_q} + 9'(STEP);
      diff9    = {1'b0, speed_q} - 9'(STEP);
      speed_d  = speed_q;
      if (!conflict) begin
         if (up_req)      speed_d = sum9[8]  ? 8'hFF : sum9[7:0];
         else if (dn_req) speed_d = diff9[8] ? 8'h00 : diff9[7:0];
      end
      stop_d    = stop_q ^ press_q[B_STOP];
      changed_d = (speed_d != speed_q) || (stop_d != stop_q);
   end

   // Output and repeat registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt_q  <= '0;
         rpt_phase_q <= 1'b0;
         rpt_up_q    <= 1'b0;
         rpt_dn_q    <= 1'b0;
         speed_q     <= 8'(INIT_SPEED);
         stop_q      <= 1'b0;
         changed_q   <= 1'b0;
      end else begin
         hold_cnt_q  <= hold_cnt_d;
         rpt_phase_q <= rpt_phase_d;
         rpt_up_q    <= rpt_up_d;
         rpt_dn_q    <= rpt_dn_d;
         speed_q     <= speed_d;
         stop_q      <= stop_d;
         changed_q   <= changed_d;
      end
   end

   assign speed   = speed_q;
   assign stop    = stop_q;
   assign changed = changed_q;

endmodule

// File: tb/tb_speed_select.sv
// Directed bench for speed_select with a 4-cycle tick. All button edges are
// driven just after a clock edge that is a multiple of 4 cycles after reset
// release, so debounce and repeat timing is fixed and hand-computable.
module tb_speed_select;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_up, btn_down, btn_stop;
   logic [7:0] speed;
   logic       stop, changed;
   logic       btn_down2;
   logic [7:0] speed2;
   logic       stop2, changed2;

   int checks = 0;
   int errors = 0;
   int chg_cnt = 0;
   int chg2_cnt = 0;
   int exp_total = 0;
   logic [8:0] exp_q[$];
   logic [8:0] exp_head;

   speed_select #(
      .TICK_M(4), .DB_MS(3), .HOLD_MS(5), .RPT_MS(2), .STEP(8), .INIT_SPEED(0)
   ) u_dut (
      .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
      .btn_stop(btn_stop), .speed(speed), .stop(stop), .changed(changed)
   );

   // Second instance starts at speed 4 to exercise down saturation to 0.
   speed_select #(
      .TICK_M(4), .DB_MS(3), .HOLD_MS(5), .RPT_MS(2), .STEP(8), .INIT_SPEED(4)
   ) u_dut2 (
      .clk(clk), .reset(reset), .btn_up(1'b0), .btn_down(btn_down2),
      .btn_stop(1'b0), .speed(speed2), .stop(stop2), .changed(changed2)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Scoreboard: every changed pulse consumes the next expected {stop, speed}.
   always @(negedge clk) begin
      if (changed === 1'b1) begin
         chg_cnt++;
         if (exp_q.size() > 0) begin
            exp_head = exp_q.pop_front();
            check_val("chg_value", 32'({stop, speed}), 32'(exp_head));
         end
      end
      if (changed2 === 1'b1) chg2_cnt++;
   end

   task automatic expect_chg(input logic [8:0] v);
      exp_q.push_back(v);
      exp_total++;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Three reset edges; outputs are checked while reset is still asserted.
   task automatic do_reset();
      reset = 1'b1;
      step(3);
      check_val("rst_speed", 32'(speed), 32'd0);
      check_val("rst_stop", 32'(stop), 32'd0);
      check_val("rst_changed", 32'(changed), 32'd0);
      check_val("rst_speed2", 32'(speed2), 32'd4);
      reset = 1'b0;
   endtask

   // mask = {stop, down, up}; held for hold_ticks, then 10 quiet ticks.
   task automatic press_mask(input logic [2:0] m, input int hold_ticks);
      {btn_stop, btn_down, btn_up} = m;
      step(4 * hold_ticks);
      {btn_stop, btn_down, btn_up} = 3'b000;
      step(40);
   endtask

   task automatic check_counts(input string tag);
      check_val({tag, "_chg_cnt"}, 32'(chg_cnt), 32'(exp_total));
      check_val({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      {btn_stop, btn_down, btn_up} = 3'b000;
      btn_down2 = 1'b0;
      do_reset();

      // Idle after reset.
      step(40);
      check_val("idle_speed", 32'(speed), 32'd0);
      check_val("idle_stop", 32'(stop), 32'd0);
      check_counts("idle");

      // Down from 4 saturates at 0; a second down makes no change.
      btn_down2 = 1'b1; step(16); btn_down2 = 1'b0; step(40);
      check_val("dn_sat_speed", 32'(speed2), 32'd0);
      btn_down2 = 1'b1; step(16); btn_down2 = 1'b0; step(40);
      check_val("dn_sat_again", 32'(speed2), 32'd0);
      check_val("dn_sat_chg", 32'(chg2_cnt), 32'd1);
      check_val("dn_sat_stop", 32'(stop2), 32'd0);

      // Two one-tick glitches, then a clean 4-tick press.
      btn_up = 1'b1; step(4); btn_up = 1'b0; step(4);
      btn_up = 1'b1; step(4); btn_up = 1'b0; step(8);
      check_val("glitch_speed", 32'(speed), 32'd0);
      expect_chg({1'b0, 8'd8});
      press_mask(3'b001, 4);
      check_val("press_speed", 32'(speed), 32'd8);
      check_counts("glitch");

      // Hold up 20 ticks: step at debounce, +5 ticks, then every 2 ticks.
      do_reset();
      for (int k = 1; k <= 9; k++) expect_chg({1'b0, 8'(8 * k)});
      btn_up = 1'b1;
      step(32); check_val("hold_before_rpt", 32'(speed), 32'd8);
      step(1);  check_val("hold_first_rpt", 32'(speed), 32'd16);
      step(8);  check_val("hold_second_rpt", 32'(speed), 32'd24);
      step(39);
      btn_up = 1'b0;
      step(40); check_val("hold_final", 32'(speed), 32'd72);
      step(40); check_val("hold_after_rel", 32'(speed), 32'd72);
      check_counts("hold");

      // Long hold to 248, then saturate at 255, then step down once.
      do_reset();
      for (int k = 1; k <= 31; k++) expect_chg({1'b0, 8'(8 * k)});
      btn_up = 1'b1; step(256); btn_up = 1'b0; step(40);
      check_val("long_hold", 32'(speed), 32'd248);
      expect_chg({1'b0, 8'd255});
      press_mask(3'b001, 4);
      check_val("sat_255", 32'(speed), 32'd255);
      press_mask(3'b001, 4);
      check_val("sat_255_again", 32'(speed), 32'd255);
      expect_chg({1'b0, 8'd247});
      press_mask(3'b010, 4);
      check_val("down_247", 32'(speed), 32'd247);
      check_counts("sat");

      // Up and down together, stop toggles, stop with step in one cycle.
      do_reset();
      expect_chg({1'b0, 8'd8});
      press_mask(3'b001, 4);
      press_mask(3'b011, 10);
      check_val("both_held", 32'(speed), 32'd8);
      expect_chg({1'b1, 8'd8});
      press_mask(3'b100, 4);
      check_val("stop_on", 32'(stop), 32'd1);
      expect_chg({1'b0, 8'd8});
      press_mask(3'b100, 4);
      check_val("stop_off", 32'(stop), 32'd0);
      expect_chg({1'b1, 8'd16});
      press_mask(3'b101, 4);
      check_val("stop_step_speed", 32'(speed), 32'd16);
      check_val("stop_step_stop", 32'(stop), 32'd1);
      check_counts("combo");

      // Reset during WAIT_HIGH aborts the pending press.
      do_reset();
      btn_up = 1'b1; step(8);
      do_reset();
      btn_up = 1'b0; step(60);
      check_val("abort_speed", 32'(speed), 32'd0);
      check_counts("abort");

      // Button held across reset release is debounced afresh: one step.
      btn_up = 1'b1; step(8);
      do_reset();
      expect_chg({1'b0, 8'd8});
      step(16); btn_up = 1'b0; step(40);
      check_val("fresh_speed", 32'(speed), 32'd8);
      check_counts("fresh");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/speed_select.md
SPEED_SELECT -- requirements
Module: speed_select

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
  - TICK_M, 100_000, clk cycles per internal 1 ms tick (100 MHz clock).
  - DB_MS, 20, consecutive stable ticks required to accept a button level.
  - HOLD_MS, 500, ticks a single direction button is held before auto-repeat starts.
  - RPT_MS, 100, ticks between auto-repeat steps.
  - STEP, 8, speed increment/decrement per step.
  - INIT_SPEED, 0, speed value after reset.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
  - clk, in, 1, the single clock; all logic is clocked on its rising edge.
  - reset, in, 1, synchronous active-high reset.
  - btn_up, in, 1, raw asynchronous pushbutton; increase speed.
  - btn_down, in, 1, raw asynchronous pushbutton; decrease speed.
  - btn_stop, in, 1, raw asynchronous pushbutton; toggle stop.
  - speed, out, 8, registered speed setting, feeds the chaser speed input.
  - stop, out, 1, registered freeze request, feeds the chaser stop input.
  - changed, out, 1, one-cycle pulse on any change of speed or stop.
REQ-003 There SHALL be one clock, and reset SHALL be synchronous and active-high, sampled only on the rising edge of clk.

Function
REQ-004 Each button SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-005 A free-running prescaler SHALL count 0..TICK_M-1 and assert a 1-cycle tick when it wraps.
REQ-006 Each button SHALL have its own debounce FSM with states LOW, WAIT_HIGH, HIGH and WAIT_LOW:
  - LOW -> WAIT_HIGH when the synchronized input is 1; the counter clears.
  - WAIT_HIGH -> LOW as soon as the input is 0.
  - WAIT_HIGH counts ticks; on reaching DB_MS -> HIGH.
  - HIGH and WAIT_LOW mirror this for release.
  - The debounced level is 1 in HIGH and WAIT_LOW.
REQ-007 The entry into HIGH SHALL generate a 1-cycle press pulse for that button.
REQ-008 The stop press pulse SHALL toggle stop in the next cycle.
REQ-009 An up press pulse SHALL set speed to min(speed+STEP, 255) in the next cycle, computed with 9 bits and saturated, never wrapping.
REQ-010 A down press pulse SHALL set speed to max(speed-STEP, 0) in the next cycle, saturating and never wrapping.
REQ-011 Auto-repeat SHALL use a hold counter that runs while exactly one of the up/down debounced levels is 1:
  - After HOLD_MS ticks, one step is applied.
  - A further step is applied every RPT_MS ticks thereafter while the button stays held.
  - The counter clears on release.
REQ-012 When the up and down debounced levels are both 1, or their press pulses coincide, the block SHALL make no speed change and SHALL clear the hold counter.
REQ-013 Auto-repeat SHALL continue at saturation without changing speed, and changed SHALL NOT pulse when speed is unchanged.
REQ-014 changed SHALL be 1 for exactly the cycle in which the registered speed or stop differs from its previous value.
REQ-015 Stop toggling and speed stepping in the same cycle SHALL both take effect.
REQ-016 speed and stop SHALL be registered outputs with no combinational path from any input.

Reset
REQ-017 While reset is 1 at a clk edge, the block SHALL drive:
  - speed = INIT_SPEED, stop = 0, changed = 0;
  - the prescaler, all debounce FSMs (LOW), counters and synchronizers cleared.
REQ-018 Reset asserted mid-debounce or mid-hold SHALL abort that operation with no pending step.
REQ-019 A button already held when reset deasserts SHALL be debounced afresh and SHALL produce one press pulse after DB_MS ticks.

Verification (sim parameters TICK_M=4, DB_MS=3, HOLD_MS=5, RPT_MS=2, STEP=8, INIT_SPEED=0)
REQ-020 Reset then idle -> speed=0, stop=0, changed=0 throughout.
REQ-021 btn_up high for 4 ticks with 1-tick glitches before it -> glitches ignored, exactly one step to speed=8, one changed pulse.
REQ-022 Hold btn_up 20 ticks from speed=0 -> steps at debounce, +5 ticks, then every 2 ticks; speed sequence 8, 16, 24, ... and no change after release.
REQ-023 Speed=248, press up twice -> 255, then 255 with no changed pulse; speed=4, press down -> 0.
REQ-024 btn_up and btn_down pressed in the same cycle and held -> speed unchanged, no repeat; btn_stop press -> stop toggles 0->1, next press 1->0.
REQ-025 Assert reset during WAIT_HIGH of btn_up -> no step occurs, outputs at reset values.
